eth_wrr_mux: RTL and testbench

- Next-generation Ethernet frame multiplexer: merges S_COUNT Ethernet header+payload streams onto one output.
- Arbitrates with weighted round-robin (WRR): each port may send up to cfg_weight[i] consecutive frames per turn.
- Registered header output; payload through a 2-entry skid buffer.
- Sits between per-protocol frame generators and the MAC TX path.

---
 rtl/eth_wrr_mux.sv | 233 +++++++++++++++++++++++
 tb/tb_eth_wrr_mux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_wrr_mux.sv
// eth_wrr_mux: merges S_COUNT Ethernet header+payload streams onto one output
// using weighted round-robin; each port may send up to cfg_weight[i] consecutive
// frames per turn (weight 0 disables the port).
// Header is registered (valid the cycle after s_eth_hdr_ready pulses); payload
// passes a 2-entry skid buffer (1 cycle latency, full throughput, registered
// input ready).
// Ports: s_eth_* per-port header/payload inputs (flattened, port i at slice i),
// cfg_weight per-port weights, m_eth_* merged output, busy = frame in progress,
// cur_port = granted port.
// Optional build macro ETH_WRR_MUX_STATS_EN adds stat_clear input and
// stat_frames output (per-port 32-bit frame counters).
module eth_wrr_mux #(
  parameter int S_COUNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = (DATA_WIDTH / 8),
  parameter int USER_WIDTH   = 1,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT-1:0]              s_eth_hdr_valid,
  output logic [S_COUNT-1:0]              s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]           s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]           s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]           s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_eth_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_eth_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]              s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]              s_eth_payload_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_eth_payload_axis_tuser,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
  output logic                            m_eth_hdr_valid,
  input  logic                            m_eth_hdr_ready,
  output logic [47:0]                     m_eth_dest_mac,
  output logic [47:0]                     m_eth_src_mac,
  output logic [15:0]                     m_eth_type,
  output logic [DATA_WIDTH-1:0]           m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_eth_payload_axis_tkeep,
  output logic                            m_eth_payload_axis_tvalid,
  input  logic                            m_eth_payload_axis_tready,
  output logic                            m_eth_payload_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_eth_payload_axis_tuser,
  output logic                            busy,
  output logic [$clog2(S_COUNT)-1:0]      cur_port
`ifdef ETH_WRR_MUX_STATS_EN
  ,
  input  logic                            stat_clear,
  output logic [S_COUNT*32-1:0]           stat_frames
`endif
);

  localparam int PW = $clog2(S_COUNT);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                  state, state_next;
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [S_COUNT-1:0]      elig, hdr_ready_int;
  logic [PW-1:0]           sel_port;
  logic                    sel_found, sel_reload, hdr_take;

  // payload path from the granted port into the skid buffer
  logic                    in_valid, in_last, in_xfer_last;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [KEEP_WIDTH-1:0]   in_keep;
  logic [USER_WIDTH-1:0]   in_user;

  logic                    in_ready_reg, in_ready_early;
  logic                    out_valid_next, temp_valid_reg, temp_valid_next;
  logic                    store_in_to_out, store_in_to_temp, store_temp_to_out;
  logic [DATA_WIDTH-1:0]   temp_data;
  logic [KEEP_WIDTH-1:0]   temp_keep;
  logic                    temp_last;
  logic [USER_WIDTH-1:0]   temp_user;

  always_comb begin
    for (int i = 0; i < S_COUNT; i++)
      elig[i] = s_eth_hdr_valid[i] && (cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
  end

  assign in_valid     = (state == PAYLOAD) && s_eth_payload_axis_tvalid[cur_port];
  assign in_last      = s_eth_payload_axis_tlast[cur_port];
  assign in_data      = s_eth_payload_axis_tdata[cur_port*DATA_WIDTH +: DATA_WIDTH];
  assign in_user      = s_eth_payload_axis_tuser[cur_port*USER_WIDTH +: USER_WIDTH];
  assign in_keep      = KEEP_ENABLE ? s_eth_payload_axis_tkeep[cur_port*KEEP_WIDTH +: KEEP_WIDTH]
                                    : {KEEP_WIDTH{1'b1}};
  assign in_xfer_last = in_valid && in_ready_reg && in_last;

  // Arbitration and next state. The current port keeps the grant only while it
  // still has credit; otherwise scan from cur_port+1 with wrap (cur_port itself
  // is the last candidate) and reload credit from its weight.
  always_comb begin
    state_next    = state;
    sel_found     = 1'b0;
    sel_reload    = 1'b0;
    sel_port      = cur_port;
    hdr_take      = 1'b0;
    hdr_ready_int = '0;
    case (state)
      IDLE: begin
        if (elig[cur_port] && credit != '0) begin
          sel_found = 1'b1;
        end else begin
          for (int k = 1; k <= S_COUNT; k++) begin
            if (!sel_found && elig[(int'(cur_port) + k) % S_COUNT]) begin
              sel_found  = 1'b1;
              sel_reload = 1'b1;
              sel_port   = PW'((int'(cur_port) + k) % S_COUNT);
            end
          end
        end
        // a pending output header blocks acceptance of the next one
        if (sel_found && (!m_eth_hdr_valid || m_eth_hdr_ready)) begin
          hdr_take                = 1'b1;
          hdr_ready_int[sel_port] = 1'b1;
          state_next              = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (in_xfer_last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are masked during reset so no source sees a transfer
  // that the reset is about to discard.
  assign s_eth_hdr_ready = rst ? '0 : hdr_ready_int;

  always_comb begin
    s_eth_payload_axis_tready = '0;
    if (!rst && state == PAYLOAD)
      s_eth_payload_axis_tready[cur_port] = in_ready_reg;
  end

  // Skid buffer control: output register first, temp register only when the
  // output is stalled while the registered input ready was still high.
  always_comb begin
    out_valid_next    = m_eth_payload_axis_tvalid;
    temp_valid_next   = temp_valid_reg;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    in_ready_early    = m_eth_payload_axis_tready ||
                        (!temp_valid_reg && (!m_eth_payload_axis_tvalid || !in_valid));
    if (in_ready_reg) begin
      if (m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid) begin
        out_valid_next  = in_valid;
        store_in_to_out = 1'b1;
      end else begin
        temp_valid_next  = in_valid;
        store_in_to_temp = 1'b1;
      end
    end else if (m_eth_payload_axis_tready) begin
      out_valid_next    = temp_valid_reg;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      cur_port                  <= '0;
      credit                    <= '0;
      busy                      <= 1'b0;
      m_eth_hdr_valid           <= 1'b0;
      in_ready_reg              <= 1'b0;
      m_eth_payload_axis_tvalid <= 1'b0;
      temp_valid_reg            <= 1'b0;
    end else begin
      state                     <= state_next;
      busy                      <= (state_next == PAYLOAD);
      in_ready_reg              <= in_ready_early;
      m_eth_payload_axis_tvalid <= out_valid_next;
      temp_valid_reg            <= temp_valid_next;
      if (hdr_take) begin
        cur_port        <= sel_port;
        credit          <= (sel_reload ? cfg_weight[sel_port*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                                       : credit) - WEIGHT_WIDTH'(1);
        m_eth_hdr_valid <= 1'b1;
      end else begin
        if (m_eth_hdr_ready)
          m_eth_hdr_valid <= 1'b0;
        // a port that is not presenting a header forfeits its remaining turn
        if (state == IDLE && !elig[cur_port])
          credit <= '0;
      end
    end
  end

  // datapath registers carry no reset
  always_ff @(posedge clk) begin
    if (hdr_take) begin
      m_eth_dest_mac <= s_eth_dest_mac[sel_port*48 +: 48];
      m_eth_src_mac  <= s_eth_src_mac[sel_port*48 +: 48];
      m_eth_type     <= s_eth_type[sel_port*16 +: 16];
    end
    if (store_in_to_out) begin
      m_eth_payload_axis_tdata <= in_data;
      m_eth_payload_axis_tkeep <= in_keep;
      m_eth_payload_axis_tlast <= in_last;
      m_eth_payload_axis_tuser <= in_user;
    end else if (store_temp_to_out) begin
      m_eth_payload_axis_tdata <= temp_data;
      m_eth_payload_axis_tkeep <= temp_keep;
      m_eth_payload_axis_tlast <= temp_last;
      m_eth_payload_axis_tuser <= temp_user;
    end
    if (store_in_to_temp) begin
      temp_data <= in_data;
      temp_keep <= in_keep;
      temp_last <= in_last;
      temp_user <= in_user;
    end
  end

`ifdef ETH_WRR_MUX_STATS_EN
  // clear has priority over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stat_clear)
      stat_frames <= '0;
    else if (in_xfer_last)
      stat_frames[cur_port*32 +: 32] <= stat_frames[cur_port*32 +: 32] + 32'd1;
  end
`else
  // no frame counters in this build
`endif

endmodule

// File: tb/tb_eth_wrr_mux.sv
module tb_eth_wrr_mux;
  localparam int S = 4, DW = 8, KW = 1, UW = 1, WW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [S-1:0]      s_hdr_valid, s_hdr_ready, s_tvalid, s_tready, s_tlast;
  logic [S*48-1:0]   s_dest, s_src;
  logic [S*16-1:0]   s_type;
  logic [S*DW-1:0]   s_tdata;
  logic [S*KW-1:0]   s_tkeep;
  logic [S*UW-1:0]   s_tuser;
  logic [S*WW-1:0]   cfg_weight;
  logic              m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast, busy;
  logic [47:0]       m_dest, m_src;
  logic [15:0]       m_type;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic [1:0]        cur_port;
`ifdef ETH_WRR_MUX_STATS_EN
  logic              stat_clear = 1'b0;
  logic [S*32-1:0]   stat_frames;
  logic              clr_on_last = 1'b0;
`endif

  eth_wrr_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .cfg_weight(cfg_weight),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .busy(busy), .cur_port(cur_port)
`ifdef ETH_WRR_MUX_STATS_EN
    , .stat_clear(stat_clear), .stat_frames(stat_frames)
`endif
  );

  // source model state per port
  int frames_total[S], frame_len[S], hdr_sent[S], pay_frame[S], pay_beat[S], hdr_rdy_seen[S];
  int obs_hdr_port[$];
  logic [8:0] obs_beat[$];   // {tlast, tdata}
  int busy_cycles;
  int tog;
  int total = 0, bad = 0;

  // hand-computed grant orders
  int exp1[12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int exp2[12] = '{1, 3, 3, 0, 0, 0, 1, 3, 3, 0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < S; i++) begin
      s_hdr_valid[i]       = hdr_sent[i] < frames_total[i];
      s_dest[i*48 +: 48]   = {8'(i), 32'h0, 8'(hdr_sent[i])};
      s_src[i*48 +: 48]    = {40'h0, 8'(i)};
      s_type[i*16 +: 16]   = 16'h0800 + 16'(i);
      s_tvalid[i]          = pay_frame[i] < frames_total[i];
      s_tdata[i*DW +: DW]  = {2'(i), 2'(pay_frame[i]), 4'(pay_beat[i])};
      s_tlast[i]           = (pay_beat[i] == frame_len[i] - 1);
      s_tkeep[i*KW +: KW]  = '1;
      s_tuser[i*UW +: UW]  = '0;
    end
  endtask

  // one clock: sample handshakes at negedge, advance sources after posedge
  task automatic step();
    logic [S-1:0] hh, ph;
    @(negedge clk);
    hh = s_hdr_valid & s_hdr_ready;
    ph = s_tvalid & s_tready;
    for (int i = 0; i < S; i++) if (s_hdr_ready[i]) hdr_rdy_seen[i]++;
    if (m_hdr_valid && m_hdr_ready) obs_hdr_port.push_back(int'(m_dest[47:40]));
    if (m_tvalid && m_tready) obs_beat.push_back({m_tlast, m_tdata});
    if (busy) busy_cycles++;
`ifdef ETH_WRR_MUX_STATS_EN
    if (clr_on_last && ph[2] && s_tlast[2]) stat_clear = 1'b1;
`endif
    @(posedge clk);
    #1;
`ifdef ETH_WRR_MUX_STATS_EN
    if (stat_clear) clr_on_last = 1'b0;
    stat_clear = 1'b0;
`endif
    for (int i = 0; i < S; i++) begin
      if (hh[i]) hdr_sent[i]++;
      if (ph[i]) begin
        if (pay_beat[i] == frame_len[i] - 1) begin
          pay_beat[i] = 0;
          pay_frame[i]++;
        end else pay_beat[i]++;
      end
    end
    if (tog != 0) m_tready = !m_tready;
    drive_sources();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < S; i++) begin
      frames_total[i] = 0; frame_len[i] = 1; hdr_sent[i] = 0;
      pay_frame[i] = 0; pay_beat[i] = 0; hdr_rdy_seen[i] = 0;
    end
    drive_sources();
  endtask

  task automatic clear_obs();
    obs_hdr_port.delete();
    obs_beat.delete();
    busy_cycles = 0;
    for (int i = 0; i < S; i++) hdr_rdy_seen[i] = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_sources();
    m_tready = 1'b1;
    tog = 0;
    step();
    step();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c = 0;
    while (obs_beat.size() < n && c < budget) begin step(); c++; end
    for (int k = 0; k < 8; k++) step();
    check(tag, obs_beat.size(), n);
  endtask

  task automatic wait_hdrs(input string tag, input int n, input int budget);
    int c = 0;
    while (obs_hdr_port.size() < n && c < budget) begin step(); c++; end
    check(tag, (obs_hdr_port.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    m_hdr_ready = 1'b1;
    m_tready    = 1'b1;
    tog         = 0;
    cfg_weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    clear_sources();
    for (int i = 0; i < S; i++) frames_total[i] = 1;
    drive_sources();
    // reset state, with every port offering a header
    step();
    step();
    @(negedge clk);
    check("rst hdr_valid", m_hdr_valid, 0);
    check("rst tvalid", m_tvalid, 0);
    check("rst busy", busy, 0);
    check("rst cur_port", cur_port, 0);
    check("rst hdr_ready", s_hdr_ready, 0);
    check("rst tready", s_tready, 0);

    // T1: equal weights, 3 frames x 4 beats per port
    reset_dut();
    for (int i = 0; i < S; i++) begin frames_total[i] = 3; frame_len[i] = 4; end
    drive_sources();
    wait_beats("t1 beat count", 48, 600);
    check("t1 hdr count", obs_hdr_port.size(), 12);
    for (int f = 0; f < 12; f++)
      check($sformatf("t1 order %0d", f), obs_hdr_port[f], exp1[f]);
    for (int j = 0; j < 48; j++)
      check($sformatf("t1 beat %0d", j), obs_beat[j],
            {(j % 4) == 3, 2'(exp1[j / 4]), 2'((j / 4) / 4), 4'(j % 4)});

    // T2: weights {3,1,0,2}, all ports continuously valid
    cfg_weight = {4'd2, 4'd0, 4'd1, 4'd3};
    reset_dut();
    for (int i = 0; i < S; i++) begin frames_total[i] = 1000; frame_len[i] = 2; end
    drive_sources();
    wait_hdrs("t2 hdr count", 12, 400);
    for (int f = 0; f < 12; f++)
      check($sformatf("t2 order %0d", f), obs_hdr_port[f], exp2[f]);
    check("t2 port2 never ready", hdr_rdy_seen[2], 0);

    // T3: 16-beat frame from port 3 with output ready toggling
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    reset_dut();
    frames_total[3] = 1; frame_len[3] = 16;
    tog = 1;
    drive_sources();
    wait_beats("t3 beat count", 16, 200);
    for (int j = 0; j < 16; j++)
      check($sformatf("t3 beat %0d", j), obs_beat[j], {j == 15, 2'd3, 2'd0, 4'(j)});

    // T4: single-beat frame on port 1
    reset_dut();
    frames_total[1] = 1; frame_len[1] = 1;
    drive_sources();
    wait_beats("t4 beat count", 1, 50);
    check("t4 hdr count", obs_hdr_port.size(), 1);
    check("t4 hdr port", obs_hdr_port[0], 1);
    check("t4 beat", obs_beat[0], {1'b1, 8'h40});
    check("t4 busy cycles", busy_cycles, 1);
    check("t4 tkeep", m_tkeep, 1);
    check("t4 tuser", m_tuser, 0);
    check("t4 busy after", busy, 0);

    // T5: reset in the middle of an 8-beat frame from port 0
    reset_dut();
    frames_total[0] = 1; frame_len[0] = 8;
    drive_sources();
    begin
      int c = 0;
      while (obs_beat.size() < 4 && c < 100) begin step(); c++; end
    end
    check("t5 beats before rst", obs_beat.size(), 4);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("t5 hdr_valid", m_hdr_valid, 0);
    check("t5 tvalid", m_tvalid, 0);
    check("t5 busy", busy, 0);
    check("t5 tready", s_tready, 0);
    clear_sources();
    frames_total[0] = 1; frame_len[0] = 2;
    frames_total[1] = 1; frame_len[1] = 2;
    drive_sources();
    step();
    rst = 1'b0;
    clear_obs();
    wait_beats("t5 beat count", 4, 100);
    check("t5 first port", obs_hdr_port[0], 1);
    check("t5 second port", obs_hdr_port[1], 0);
    check("t5 beat0", obs_beat[0], {1'b0, 8'h40});
    check("t5 beat3", obs_beat[3], {1'b1, 8'h01});

`ifdef ETH_WRR_MUX_STATS_EN
    // stats: 5 frames on port 2, then a clear colliding with a tlast
    reset_dut();
    frames_total[2] = 5; frame_len[2] = 2;
    drive_sources();
    wait_beats("st beat count", 10, 200);
    check("st port2 count", stat_frames[2*32 +: 32], 5);
    check("st port0 count", stat_frames[0 +: 32], 0);
    frames_total[2] = 6;
    clr_on_last = 1'b1;
    drive_sources();
    wait_beats("st beat count2", 12, 100);
    check("st clear wins", stat_frames[2*32 +: 32], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
